// File: rtl/cond_pkg.sv
// Shared definitions for the compare-condition logic: the condition codes
// and the nullify FSM state encoding.
package cond_pkg;

  localparam logic [2:0] COND_NEVER = 3'd0;
  localparam logic [2:0] COND_EQ    = 3'd1;
  localparam logic [2:0] COND_LT    = 3'd2;
  localparam logic [2:0] COND_LE    = 3'd3;
  localparam logic [2:0] COND_LTU   = 3'd4;
  localparam logic [2:0] COND_LEU   = 3'd5;
  localparam logic [2:0] COND_SV    = 3'd6;
  localparam logic [2:0] COND_OD    = 3'd7;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_NULLIFY = 1'b1
  } state_e;

endpackage

// File: rtl/cond_eval.sv
// Combinational evaluation of the compare condition from the ALU flags.
// The branch unit also uses this block, so it stays free of state.
module cond_eval
  import cond_pkg::*;
(
  input  logic       i_z,
  input  logic       i_n,
  input  logic       i_c,
  input  logic       i_v,
  input  logic       i_lsb,
  input  logic [2:0] i_cond,
  input  logic       i_cond_neg,
  output logic       o_t
);

  logic w_raw;

  // Select the raw condition; the negate bit turns "never" into "always".
  always_comb begin
    w_raw = 1'b0;
    case (i_cond)
      COND_NEVER: w_raw = 1'b0;
      COND_EQ:    w_raw = i_z;
      COND_LT:    w_raw = i_n ^ i_v;
      COND_LE:    w_raw = (i_n ^ i_v) | i_z;
      COND_LTU:   w_raw = i_c;
      COND_LEU:   w_raw = i_c | i_z;
      COND_SV:    w_raw = i_v;
      COND_OD:    w_raw = i_lsb;
      default:    w_raw = 1'b0;
    endcase
  end

  assign o_t = w_raw ^ i_cond_neg;

endmodule

// File: rtl/cond_nullify_unit.sv
// Execute-stage back end: registers the ALU result, produces branch-taken and
// nullify decisions, and owns the PSW carry/borrow bit fed back to the ALU.
module cond_nullify_unit
  import cond_pkg::*;
#(
  parameter int   WIDTH    = 32,
  parameter logic CB_RESET = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             stall,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             z_in,
  input  logic             n_in,
  input  logic             c_in,
  input  logic             v_in,
  input  logic [2:0]       cond,
  input  logic             cond_neg,
  input  logic             nullify_en,
  input  logic             branch_en,
  input  logic             carry_we,
  output logic             ci_out,
  output logic [WIDTH-1:0] result_out,
  output logic             result_valid,
  output logic             branch_taken,
  output logic             nullify_next
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             w_accept;
  logic             w_commit;
  logic             w_t;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             r_branch_taken;
  logic             r_cb;

  assign w_accept = valid_in & ~stall;

  cond_eval u_cond_eval (
    .i_z        (z_in),
    .i_n        (n_in),
    .i_c        (c_in),
    .i_v        (v_in),
    .i_lsb      (alu_out[0]),
    .i_cond     (cond),
    .i_cond_neg (cond_neg),
    .o_t        (w_t)
  );

  // FSM state register; reset wins even in the middle of a squash.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next state and commit decision: an accepted instruction in NULLIFY is
  // squashed and consumes the pending nullify; bubbles and stalls keep it.
  always_comb begin
    w_state_nxt = r_state;
    w_commit    = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_RUN: begin
          w_commit    = 1'b1;
          w_state_nxt = (nullify_en & w_t) ? ST_NULLIFY : ST_RUN;
        end
        ST_NULLIFY: w_state_nxt = ST_RUN;
        default:    w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Result, valid/branch pulses and PSW carry/borrow, all one cycle after accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_branch_taken <= 1'b0;
      r_cb           <= CB_RESET;
    end else begin
      r_result_valid <= w_commit;
      r_branch_taken <= w_commit & branch_en & w_t;
      if (w_commit)            r_result <= alu_out;
      if (w_commit & carry_we) r_cb     <= c_in;
    end
  end

  assign ci_out       = r_cb;
  assign result_out   = r_result;
  assign result_valid = r_result_valid;
  assign branch_taken = r_branch_taken;
  assign nullify_next = (r_state == ST_NULLIFY);

endmodule

// File: tb/tb_cond_nullify_unit.sv
// Directed, table-driven bench for cond_nullify_unit with hand-computed
// expectations; vectors run back to back so FSM and carry state carry over.
module tb_cond_nullify_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in, stall;
  logic [W-1:0] alu_out;
  logic         z_in, n_in, c_in, v_in;
  logic [2:0]   cond;
  logic         cond_neg, nullify_en, branch_en, carry_we;
  logic         ci_out;
  logic [W-1:0] result_out;
  logic         result_valid, branch_taken, nullify_next;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cond_nullify_unit #(.WIDTH(W), .CB_RESET(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .stall        (stall),
    .alu_out      (alu_out),
    .z_in         (z_in),
    .n_in         (n_in),
    .c_in         (c_in),
    .v_in         (v_in),
    .cond         (cond),
    .cond_neg     (cond_neg),
    .nullify_en   (nullify_en),
    .branch_en    (branch_en),
    .carry_we     (carry_we),
    .ci_out       (ci_out),
    .result_out   (result_out),
    .result_valid (result_valid),
    .branch_taken (branch_taken),
    .nullify_next (nullify_next)
  );

  typedef struct {
    logic         valid, stall;
    logic [W-1:0] alu;
    logic         z, n, c, v;
    logic [2:0]   cond;
    logic         neg, nen, ben, cwe;
    logic         e_rv, e_bt, e_ci, e_nn;
    logic [W-1:0] e_res;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic valid, logic stl, logic [W-1:0] alu,
                              logic z, logic n, logic c, logic v, logic [2:0] cd,
                              logic neg, logic nen, logic ben, logic cwe,
                              logic e_rv, logic e_bt, logic [W-1:0] e_res,
                              logic e_ci, logic e_nn);
    vec_t r;
    r.valid = valid; r.stall = stl; r.alu = alu;
    r.z = z; r.n = n; r.c = c; r.v = v; r.cond = cd;
    r.neg = neg; r.nen = nen; r.ben = ben; r.cwe = cwe;
    r.e_rv = e_rv; r.e_bt = e_bt; r.e_res = e_res; r.e_ci = e_ci; r.e_nn = e_nn;
    return r;
  endfunction

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    @(negedge clk);
    valid_in = t.valid; stall = t.stall; alu_out = t.alu;
    z_in = t.z; n_in = t.n; c_in = t.c; v_in = t.v; cond = t.cond;
    cond_neg = t.neg; nullify_en = t.nen; branch_en = t.ben; carry_we = t.cwe;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(string tag, vec_t t);
    chk({tag, ".result_valid"}, W'(result_valid), W'(t.e_rv));
    chk({tag, ".branch_taken"}, W'(branch_taken), W'(t.e_bt));
    chk({tag, ".result_out"},   result_out,       t.e_res);
    chk({tag, ".ci_out"},       W'(ci_out),       W'(t.e_ci));
    chk({tag, ".nullify_next"}, W'(nullify_next), W'(t.e_nn));
  endtask

  initial begin
    vec_t idle, t;
    idle = mk(0,0,'0, 0,0,0,0,3'd0, 0,0,0,0, 0,0,'0,0,0);
    valid_in = 0; stall = 0; alu_out = '0; z_in = 0; n_in = 0; c_in = 0; v_in = 0;
    cond = 3'd0; cond_neg = 0; nullify_en = 0; branch_en = 0; carry_we = 0;

    // Reset state.
    rst = 1;
    drive(idle);
    drive(idle);
    check_all("reset", mk(0,0,'0,0,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0));

    // Load psw_cb=1 and enter NULLIFY, then reset mid-nullify.
    rst = 0;
    drive(mk(1,0,32'h1234, 1,0,1,0,3'd1, 0,1,0,1, 0,0,'0,0,0));
    check_all("pre_rst", mk(0,0,'0,0,0,0,0,0,0,0,0,0, 1,0,32'h1234,1,1));
    rst = 1;
    drive(mk(1,0,32'h9999, 1,0,1,0,3'd1, 0,1,1,1, 0,0,'0,0,0));
    check_all("rst_mid", mk(0,0,'0,0,0,0,0,0,0,0,0,0, 0,0,32'h0,0,0));
    rst = 0;

    //             vld stl alu           z n c v cond neg nen ben cwe | rv bt res           ci nn
    vecs.push_back(mk(1,0,32'h2C000035, 0,0,0,1,3'd2, 0,0,1,0, 1,1,32'h2C000035,0,0)); // 0 lt branch
    vecs.push_back(mk(0,0,32'h0,        0,0,0,0,3'd0, 0,0,0,0, 0,0,32'h2C000035,0,0)); // 1 pulse ends
    vecs.push_back(mk(1,0,32'h2C000035, 0,0,0,1,3'd2, 1,0,1,0, 1,0,32'h2C000035,0,0)); // 2 negated
    vecs.push_back(mk(1,0,32'h10,       1,0,0,0,3'd1, 0,1,0,0, 1,0,32'h10,0,1));       // 3 enter NULLIFY
    vecs.push_back(mk(1,0,32'h5,        1,0,1,0,3'd1, 0,0,1,1, 0,0,32'h10,0,0));       // 4 squashed
    vecs.push_back(mk(1,0,32'h77,       0,0,0,0,3'd0, 0,0,0,0, 1,0,32'h77,0,0));       // 5 commits
    vecs.push_back(mk(1,0,32'h1,        0,0,1,0,3'd0, 0,0,0,1, 1,0,32'h1,1,0));        // 6 carry write
    vecs.push_back(mk(1,0,32'h2,        1,0,0,0,3'd5, 0,0,1,0, 1,1,32'h2,1,0));        // 7 <<= via Z
    vecs.push_back(mk(1,1,32'hDEAD,     1,0,0,0,3'd1, 0,1,1,1, 0,0,32'h2,1,0));        // 8 stall hold
    vecs.push_back(mk(1,0,32'h3,        0,0,0,0,3'd7, 0,1,0,0, 1,0,32'h3,1,1));        // 9 OD -> NULLIFY
    vecs.push_back(mk(0,0,32'h0,        0,0,0,0,3'd0, 0,0,0,0, 0,0,32'h3,1,1));        // 10 bubble
    vecs.push_back(mk(0,0,32'h0,        0,0,0,0,3'd0, 0,0,0,0, 0,0,32'h3,1,1));        // 11 bubble
    vecs.push_back(mk(1,1,32'hBEEF,     0,0,0,0,3'd0, 1,0,1,0, 0,0,32'h3,1,1));        // 12 stall
    vecs.push_back(mk(1,0,32'h9,        0,0,0,0,3'd0, 1,1,1,1, 0,0,32'h3,1,0));        // 13 squashed
    vecs.push_back(mk(1,0,32'hAA,       0,1,0,0,3'd3, 0,1,1,0, 1,1,32'hAA,1,1));       // 14 branch+nullify
    vecs.push_back(mk(1,0,32'hBB,       0,0,1,0,3'd4, 0,0,1,0, 0,0,32'hAA,1,0));       // 15 squashed
    vecs.push_back(mk(1,0,32'h6,        0,0,0,1,3'd6, 0,0,1,0, 1,1,32'h6,1,0));        // 16 SV
    vecs.push_back(mk(1,0,32'h8,        0,0,1,0,3'd4, 1,0,1,0, 1,0,32'h8,1,0));        // 17 not <<
    vecs.push_back(mk(1,0,32'hC,        0,1,0,1,3'd2, 0,0,1,0, 1,0,32'hC,1,0));        // 18 N==V
    vecs.push_back(mk(1,0,32'h4,        0,0,0,0,3'd7, 1,0,1,1, 1,1,32'h4,0,0));        // 19 even, cb<=0

    for (int i = 0; i < vecs.size(); i++) begin
      t = vecs[i];
      drive(t);
      check_all($sformatf("vec%0d", i), t);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cond_nullify_unit.md
Name: cond_nullify_unit

Overview:
Execute-stage back end sitting directly downstream of the ALU. It consumes the ALU result and Z/N/C/V flags and evaluates the PA-RISC compare condition carried with the instruction. From that it produces registered branch-taken and nullify decisions, and it owns the PSW carry/borrow bit that feeds the ALU Ci input for add-with-carry and subtract-with-borrow. A two-state FSM squashes the instruction that follows a satisfied compare-and-nullify.

Parameters:
WIDTH, 32, datapath width of alu_out/result_out
CB_RESET, 0, reset value of the PSW carry/borrow bit

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
valid_in  input  1  ALU result/flags hold a live instruction this cycle
stall  input  1  pipeline hold; nothing accepted, no state change
alu_out  input  WIDTH  ALU Out
z_in, n_in, c_in, v_in  input  1 each  ALU Z, N, C, V (c_in = carry for add, borrow for sub)
cond  input  3  condition field: 0 never, 1 =, 2 < signed, 3 <= signed, 4 << unsigned, 5 <<= unsigned, 6 SV, 7 OD
cond_neg  input  1  invert condition (f bit)
nullify_en  input  1  instruction nullifies successor when condition true
branch_en  input  1  instruction is compare-and-branch
carry_we  input  1  instruction updates PSW carry/borrow
ci_out  output  1  PSW carry/borrow to ALU Ci (direct from register)
result_out  output  WIDTH  registered result
result_valid  output  1  registered: result_out is from a committed instruction
branch_taken  output  1  registered one-cycle pulse
nullify_next  output  1  high while FSM is in NULLIFY

Behaviour:
- Reset (rst=1 at clk edge, overrides everything including mid-nullify): result_out=0, result_valid=0, branch_taken=0, psw_cb=CB_RESET, FSM=RUN, nullify_next=0.
- accept = valid_in & ~stall.
- Condition truth (combinational): 0:0; 1:Z; 2:N^V; 3:(N^V)|Z; 4:C; 5:C|Z; 6:V; 7:alu_out[0]. Then t = raw ^ cond_neg (cond=0 with neg = always).
- Latency: 1 cycle; all outputs except ci_out are registers updated at the edge following acceptance.
- stall=1: result_out, psw_cb, and FSM hold; result_valid and branch_taken forced 0 next cycle.
- valid_in=0 and stall=0: result_valid=0, branch_taken=0; FSM and psw_cb hold.
- FSM RUN, accept:
  - result_out<=alu_out; result_valid<=1.
  - if carry_we, psw_cb<=c_in.
  - branch_taken<=branch_en & t.
  - if nullify_en & t, go to NULLIFY; else stay in RUN.
- FSM NULLIFY, accept: the instruction is squashed.
  - result_valid<=0, branch_taken<=0, psw_cb unchanged, result_out holds.
  - Its own nullify_en/branch_en are ignored.
  - Return to RUN.
- NULLIFY with no accept (bubble or stall): remain in NULLIFY; the squash applies to the next accepted instruction only.
- branch_en & nullify_en both set with t=1: both take effect (pulse and enter NULLIFY).
- ci_out reflects psw_cb as of the previous edge. An add-with-carry back-to-back with a carry-writer sees the updated bit the cycle after that writer is accepted.

Decomposition:
- Shared package cond_pkg: 3-bit cond code constants (COND_NEVER..COND_OD) and the FSM state encoding (ST_RUN=0, ST_NULLIFY=1).
- Sub-module cond_eval (combinational: flags, alu_out[0], cond, cond_neg -> t). It is reused by the branch unit.

Test Plan:
- Reset: assert rst with psw_cb=1 and FSM in NULLIFY -> next cycle result_valid=0, nullify_next=0, ci_out=CB_RESET, branch_taken=0.
- Signed-less branch: alu_out=0x2C000035, Z=0, N=0, C=0, V=1, cond=2, branch_en=1 -> branch_taken=1 for exactly one cycle, result_out=0x2C000035, result_valid=1; same with cond_neg=1 -> branch_taken=0.
- Nullify: cond=1, Z=1, nullify_en=1 accepted -> nullify_next=1. Next instruction (alu_out=0x5, carry_we=1, c_in=1, branch_en=1, t=1) -> result_valid=0, branch_taken=0, ci_out unchanged, nullify_next=0. The third instruction commits normally.
- Nullify across bubbles/stall: after entering NULLIFY apply 2 cycles valid_in=0, then 1 cycle stall=1 -> nullify_next stays 1 throughout. The first accepted instruction afterwards is squashed.
- Carry chain: carry_we=1, c_in=1 accepted -> ci_out=1 next cycle. An instruction with carry_we=0 and c_in=0 -> ci_out stays 1. cond=5 with C=0, Z=1 -> t=1.
- Stall hold: stall=1 while valid_in=1, carry_we=1, c_in=1 -> psw_cb, result_out, and FSM unchanged; result_valid=0.
